uart_transmitter_cfg: RTL and testbench

Parametrised successor of the single-byte UART transmitter. Adds a runtime-configurable frame format (data bits, parity, stop bits) and a small TX FIFO with a valid/ready handshake, so software can queue several characters back-to-back. Bit timing comes from the existing serial_clock_generator through its rising_edge pulse, wired to sck_rising_edge. Sits in the UART peripheral next to the receiver; sout drives the pad.

---
 rtl/uart_transmitter_cfg.sv | 180 ++++++++++++++++++
 tb/tb_uart_transmitter_cfg.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter_cfg.sv
// UART transmitter with runtime frame format (5..MAX_DATA_BITS data bits, parity, 1/2 stop bits)
// and a small TX FIFO with a valid/ready push interface; bit timing comes from sck_rising_edge.
module uart_transmitter_cfg #(
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 4,
    parameter int DBW           = $clog2(MAX_DATA_BITS + 1),
    parameter int LW            = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sck_rising_edge,
    input  logic                     tx_data_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    input  logic [DBW-1:0]           data_bits,
    input  logic [1:0]               parity_mode,
    input  logic                     stop_bits,
    output logic                     sout,
    output logic                     busy,
    output logic [LW-1:0]            fifo_level,
    output logic                     tx_done
);

    localparam int PW = LW - 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [MAX_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]            r_wrPtr;
    logic [PW-1:0]            r_rdPtr;
    logic [LW-1:0]            r_level;
    logic                     r_txReady;

    logic [2:0]               r_state;
    logic                     r_sout;
    logic                     r_txDone;
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [DBW-1:0]           r_nBits;
    logic [DBW-1:0]           r_bitCnt;
    logic                     r_parEn;
    logic                     r_parOdd;
    logic                     r_parAcc;
    logic                     r_twoStop;
    logic                     r_stopCnt;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_lastStop;
    logic [LW-1:0]            w_levelNext;
    logic [DBW-1:0]           w_nBits;

    assign w_push      = tx_data_valid && r_txReady;
    assign w_lastStop  = !r_twoStop || r_stopCnt;
    // A pop only happens on a bit pulse, either from IDLE or at the end of the final stop bit
    assign w_pop       = sck_rising_edge && (r_level != '0) &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_lastStop));
    assign w_levelNext = r_level + LW'(w_push) - LW'(w_pop);

    always_comb begin
        w_nBits = data_bits;
        if (data_bits < DBW'(5))
            w_nBits = DBW'(5);
        else if (data_bits > DBW'(MAX_DATA_BITS))
            w_nBits = DBW'(MAX_DATA_BITS);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_txReady <= 1'b1;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)
                r_rdPtr <= r_rdPtr + PW'(1);
            r_level   <= w_levelNext;
            r_txReady <= (w_levelNext != LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sout    <= 1'b1;
            r_txDone  <= 1'b0;
            r_shift   <= '0;
            r_nBits   <= DBW'(5);
            r_bitCnt  <= '0;
            r_parEn   <= 1'b0;
            r_parOdd  <= 1'b0;
            r_parAcc  <= 1'b0;
            r_twoStop <= 1'b0;
            r_stopCnt <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            // The frame format is captured with the character so later config writes cannot disturb it
            if (w_pop) begin
                r_shift   <= r_mem[r_rdPtr];
                r_nBits   <= w_nBits;
                r_parEn   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                r_parOdd  <= (parity_mode == 2'd2);
                r_twoStop <= stop_bits;
            end
            if (sck_rising_edge) begin
                case (r_state)
                    IDLE: begin
                        if (w_pop) begin
                            r_sout  <= 1'b0;
                            r_state <= START;
                        end
                    end
                    START: begin
                        r_sout   <= r_shift[0];
                        r_parAcc <= r_shift[0];
                        r_bitCnt <= '0;
                        r_state  <= DATA;
                    end
                    DATA: begin
                        if (r_bitCnt == r_nBits - DBW'(1)) begin
                            r_stopCnt <= 1'b0;
                            if (r_parEn) begin
                                r_sout  <= r_parAcc ^ r_parOdd;
                                r_state <= PARITY;
                            end else begin
                                r_sout  <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_sout   <= r_shift[1];
                            r_parAcc <= r_parAcc ^ r_shift[1];
                            r_shift  <= r_shift >> 1;
                            r_bitCnt <= r_bitCnt + DBW'(1);
                        end
                    end
                    PARITY: begin
                        r_sout    <= 1'b1;
                        r_stopCnt <= 1'b0;
                        r_state   <= STOP;
                    end
                    STOP: begin
                        if (!w_lastStop) begin
                            r_stopCnt <= 1'b1;
                        end else begin
                            r_txDone <= 1'b1;
                            if (w_pop) begin
                                r_sout  <= 1'b0;
                                r_state <= START;
                            end else begin
                                r_sout  <= 1'b1;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: begin
                        r_sout  <= 1'b1;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready   = r_txReady;
    assign fifo_level = r_level;
    assign sout       = r_sout;
    assign tx_done    = r_txDone;
    assign busy       = (r_level != '0) || (r_state != IDLE);

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// Bench for uart_transmitter_cfg: frames are predicted at push time into a scoreboard queue
// and a line monitor decodes sout on each bit pulse and compares whole frames.
module tb_uart_transmitter_cfg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       txValid = 1'b0;
    logic [8:0] txData = '0;
    logic       txReady;
    logic [3:0] dataBits = 4'd8;
    logic [1:0] parityMode = 2'd0;
    logic       stopBits = 1'b0;
    logic       sout;
    logic       busy;
    logic [2:0] fifoLevel;
    logic       txDone;

    typedef struct {
        logic [31:0] bits;
        int          len;
    } frame_t;

    frame_t expQ[$];
    int     vectors = 0;
    int     errors = 0;
    int     div = 1;
    int     divCnt = 0;
    int     doneCount = 0;
    int     framesChecked = 0;
    int     gapCount = 0;
    int     stallLevel = 0;
    logic   sawStall = 1'b0;
    logic   inFrame = 1'b0;
    logic   afterFrame = 1'b0;

    uart_transmitter_cfg #(.MAX_DATA_BITS(9), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck_rising_edge(sck),
        .tx_data_valid  (txValid),
        .tx_data        (txData),
        .tx_ready       (txReady),
        .data_bits      (dataBits),
        .parity_mode    (parityMode),
        .stop_bits      (stopBits),
        .sout           (sout),
        .busy           (busy),
        .fifo_level     (fifoLevel),
        .tx_done        (txDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic frame_t buildFrame(input logic [8:0] d, input logic [3:0] db,
                                          input logic [1:0] pm, input logic sb);
        frame_t f;
        int     n;
        int     idx;
        logic   p;
        n = (db < 4'd5) ? 5 : (db > 4'd9) ? 9 : int'(db);
        f.bits = '0;
        idx = 1;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[idx] = d[i];
            p = p ^ d[i];
            idx++;
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            f.bits[idx] = p ^ (pm == 2'd2);
            idx++;
        end
        f.bits[idx] = 1'b1;
        idx++;
        if (sb) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.len = idx;
        return f;
    endfunction

    // Bit-period pulse generator, changed only on negedge so the DUT sees it stable
    initial begin
        forever begin
            @(negedge clk);
            if (divCnt >= div - 1) begin
                divCnt = 0;
                sck = 1'b1;
            end else begin
                divCnt++;
                sck = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (txDone === 1'b1)
                doneCount++;
        end
    end

    // Line monitor: samples sout just after each bit pulse and rebuilds frames
    initial begin
        frame_t      cur;
        logic [31:0] obs;
        int          idx;
        logic        s;
        cur.bits = '0;
        cur.len = 0;
        obs = '0;
        idx = 0;
        forever begin
            @(posedge clk);
            if (sck && rst_n) begin
                #1;
                s = sout;
                if (!inFrame) begin
                    if (afterFrame && s && expQ.size() > 0)
                        gapCount++;
                    afterFrame = 1'b0;
                    if (!s) begin
                        if (expQ.size() == 0) begin
                            checkOutput("unexpected_start", 32'(expQ.size()), 32'd1);
                        end else begin
                            cur = expQ.pop_front();
                            obs = '0;
                            idx = 1;
                            inFrame = 1'b1;
                        end
                    end
                end else begin
                    obs[idx] = s;
                    idx++;
                    if (idx == cur.len) begin
                        checkOutput("frame", obs, cur.bits);
                        framesChecked++;
                        inFrame = 1'b0;
                        afterFrame = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [8:0] d);
        logic done;
        int   t;
        done = 1'b0;
        t = 0;
        @(negedge clk);
        txData = d;
        txValid = 1'b1;
        while (!done && t < 5000) begin
            if (txReady === 1'b1) begin
                expQ.push_back(buildFrame(d, dataBits, parityMode, stopBits));
                done = 1'b1;
                @(posedge clk);
            end else begin
                if (!sawStall) begin
                    sawStall = 1'b1;
                    stallLevel = int'(fifoLevel);
                end
                @(negedge clk);
                t++;
            end
        end
        if (!done)
            checkOutput("push_timeout", 32'(done), 32'd1);
        @(negedge clk);
        txValid = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (t < 30000 && !(expQ.size() == 0 && !inFrame && busy === 1'b0)) begin
            @(negedge clk);
            t++;
        end
        checkOutput("idle_timeout", 32'(t < 30000), 32'd1);
    endtask

    task automatic waitInFrame();
        int t;
        t = 0;
        while (t < 5000 && !inFrame) begin
            @(negedge clk);
            t++;
        end
        checkOutput("frame_start_timeout", 32'(inFrame), 32'd1);
    endtask

    initial begin
        int d0;
        int f0;
        int g0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_sout", sout, 32'd1);
        checkOutput("reset_busy", busy, 32'd0);
        checkOutput("reset_ready", txReady, 32'd1);
        checkOutput("reset_level", fifoLevel, 32'd0);
        checkOutput("reset_done", txDone, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] 8N1 at divider 1");
        div = 1;
        dataBits = 4'd8; parityMode = 2'd0; stopBits = 1'b0;
        d0 = doneCount; f0 = framesChecked;
        applyStimulus(9'h055);
        checkOutput("busy_after_push", busy, 32'd1);
        waitIdle();
        checkOutput("8n1_busy_low", busy, 32'd0);
        checkOutput("8n1_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("8n1_frames", 32'(framesChecked - f0), 32'd1);

        $display("[TB] 7E2 and 7O2");
        div = 4;
        dataBits = 4'd7; parityMode = 2'd1; stopBits = 1'b1;
        f0 = framesChecked;
        applyStimulus(9'h003);
        waitIdle();
        parityMode = 2'd2;
        applyStimulus(9'h003);
        waitIdle();
        parityMode = 2'd3;
        stopBits = 1'b0;
        applyStimulus(9'h07E);
        waitIdle();
        checkOutput("7bit_frames", 32'(framesChecked - f0), 32'd3);

        $display("[TB] 9N1 and data_bits clamping");
        dataBits = 4'd9; parityMode = 2'd0; stopBits = 1'b0;
        f0 = framesChecked;
        applyStimulus(9'h1A5);
        waitIdle();
        dataBits = 4'd3;
        applyStimulus(9'h1F5);
        waitIdle();
        dataBits = 4'd15; parityMode = 2'd1;
        applyStimulus(9'h0F3);
        waitIdle();
        checkOutput("clamp_frames", 32'(framesChecked - f0), 32'd3);

        $display("[TB] back-to-back burst at divider 255");
        div = 255;
        dataBits = 4'd8; parityMode = 2'd0; stopBits = 1'b0;
        sawStall = 1'b0; stallLevel = 0;
        d0 = doneCount; f0 = framesChecked; g0 = gapCount;
        for (int i = 0; i < 6; i++)
            applyStimulus(9'(8'h41 + 8'(i * 37)));
        waitIdle();
        checkOutput("burst_stall_seen", sawStall, 32'd1);
        checkOutput("burst_stall_level", 32'(stallLevel), 32'd4);
        checkOutput("burst_gaps", 32'(gapCount - g0), 32'd0);
        checkOutput("burst_done_count", 32'(doneCount - d0), 32'd6);
        checkOutput("burst_frames", 32'(framesChecked - f0), 32'd6);

        $display("[TB] config change mid-frame");
        div = 16;
        f0 = framesChecked; g0 = gapCount;
        applyStimulus(9'h05A);
        waitInFrame();
        repeat (4 * 16) @(negedge clk);
        dataBits = 4'd6; parityMode = 2'd2; stopBits = 1'b1;
        applyStimulus(9'h02D);
        waitIdle();
        checkOutput("cfg_frames", 32'(framesChecked - f0), 32'd2);
        checkOutput("cfg_gaps", 32'(gapCount - g0), 32'd0);

        $display("[TB] reset mid-frame");
        dataBits = 4'd8; parityMode = 2'd0; stopBits = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(9'(8'h11 * (i + 1)));
        waitInFrame();
        repeat (4 * 16) @(negedge clk);
        checkOutput("pre_reset_level", fifoLevel, 32'd3);
        rst_n = 1'b0;
        expQ.delete();
        inFrame = 1'b0;
        afterFrame = 1'b0;
        #1;
        checkOutput("midreset_sout", sout, 32'd1);
        checkOutput("midreset_busy", busy, 32'd0);
        checkOutput("midreset_level", fifoLevel, 32'd0);
        checkOutput("midreset_ready", txReady, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = doneCount; f0 = framesChecked;
        applyStimulus(9'h0A3);
        waitIdle();
        checkOutput("post_reset_frames", 32'(framesChecked - f0), 32'd1);
        checkOutput("post_reset_done", 32'(doneCount - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
